// File: rtl/id_pkg.sv
// -----------------------------------------------------------------------------
// id_pkg: shared definitions for the decode stage of the 8-bit core.
//   - Field widths (DW, NREGS, RAW, OPW)
//   - Opcode encoding OP_NOP..OP_HLT
//   - Decode FSM state encoding ST_RUN / ST_HALT
//   - sext4(): sign-extends a 4-bit branch offset to DW bits
// Optional build macro used by id_stage: WB_BYPASS_EN
// -----------------------------------------------------------------------------
package id_pkg;

    localparam int DW    = 8;   // data / address width
    localparam int NREGS = 4;   // register count, fixed by 2-bit fields
    localparam int RAW   = 2;   // register index width
    localparam int OPW   = 4;   // opcode width

    typedef enum logic [OPW-1:0] {
        OP_NOP = 4'h0,
        OP_ADD = 4'h1,
        OP_SUB = 4'h2,
        OP_AND = 4'h3,
        OP_OR  = 4'h4,
        OP_XOR = 4'h5,
        OP_MOV = 4'h6,
        OP_SHL = 4'h7,
        OP_LD  = 4'h8,
        OP_ST  = 4'h9,
        OP_BZ  = 4'hA,
        OP_BC  = 4'hB,
        OP_JMP = 4'hC,
        OP_JR  = 4'hD,
        OP_RSV = 4'hE,
        OP_HLT = 4'hF
    } opcode_e;

    typedef enum logic {
        ST_RUN  = 1'b0,
        ST_HALT = 1'b1
    } state_e;

    function automatic logic [DW-1:0] sext4(input logic [3:0] off);
        return {{(DW-4){off[3]}}, off};
    endfunction

endpackage

// File: rtl/id_stage_regfile_4x8.sv
// -----------------------------------------------------------------------------
// regfile_4x8: NREGS x DW register file.
//   clk      in   rising-edge clock
//   reset    in   asynchronous active-low clear of all registers
//   we       in   write enable
//   waddr    in   write index
//   wdata    in   write data
//   raddr_a  in   read port A index  -> rdata_a (asynchronous)
//   raddr_b  in   read port B index  -> rdata_b (asynchronous)
// Reads return the stored value only; a same-cycle write is visible after
// the next rising edge.
// -----------------------------------------------------------------------------
module regfile_4x8
    import id_pkg::*;
(
    input  logic           clk,
    input  logic           reset,
    input  logic           we,
    input  logic [RAW-1:0] waddr,
    input  logic [DW-1:0]  wdata,
    input  logic [RAW-1:0] raddr_a,
    input  logic [RAW-1:0] raddr_b,
    output logic [DW-1:0]  rdata_a,
    output logic [DW-1:0]  rdata_b
);

    logic [NREGS-1:0][DW-1:0] mem;

    for (genvar i = 0; i < NREGS; i++) begin : g_reg
        always_ff @(posedge clk or negedge reset) begin
            if (!reset)
                mem[i] <= '0;
            else if (we && (waddr == RAW'(i)))
                mem[i] <= wdata;
        end
    end

    assign rdata_a = mem[raddr_a];
    assign rdata_b = mem[raddr_b];

endmodule

// File: rtl/id_stage.sv
// -----------------------------------------------------------------------------
// id_stage: combinational decode stage of the 8-bit single-cycle core.
// Holds the 4x8 register file, the Z/C flags and the RUN/HALT FSM.
//   clk, reset              clock (rising edge), async active-low reset
//   Instr, NPC              fetched instruction and PC+1
//   resume                  pulse that leaves HALT
//   wb_en/wb_addr/wb_data   register write-back
//   flag_we/flag_z/flag_c   flag update from the ALU
//   PC_sel, Target          redirect to fetch (branch, jump, halt)
//   rs_val, rd_val          R[Instr[1:0]], R[Instr[3:2]]
//   alu_op, reg_we          ALU opcode (ALU class only), rd write
//   mem_re, mem_we          load / store
//   halted                  FSM is in HALT
// Build option: `define WB_BYPASS_EN forwards same-cycle write-back data to
// the read ports and same-cycle flag updates to BZ/BC.
// All outputs are held at 0 while reset is asserted.
// -----------------------------------------------------------------------------
module id_stage
    import id_pkg::*;
(
    input  logic           clk,
    input  logic           reset,
    input  logic [DW-1:0]  Instr,
    input  logic [DW-1:0]  NPC,
    input  logic           resume,
    input  logic           wb_en,
    input  logic [RAW-1:0] wb_addr,
    input  logic [DW-1:0]  wb_data,
    input  logic           flag_we,
    input  logic           flag_z,
    input  logic           flag_c,
    output logic           PC_sel,
    output logic [DW-1:0]  Target,
    output logic [DW-1:0]  rs_val,
    output logic [DW-1:0]  rd_val,
    output logic [OPW-1:0] alu_op,
    output logic           reg_we,
    output logic           mem_re,
    output logic           mem_we,
    output logic           halted
);

    opcode_e        op;
    logic [RAW-1:0] rd, rs;
    logic [3:0]     off4;

    assign op   = opcode_e'(Instr[7:4]);
    assign rd   = Instr[3:2];
    assign rs   = Instr[1:0];
    assign off4 = Instr[3:0];

    // ---------------- register file ----------------
    logic [DW-1:0] rs_reg, rd_reg, rs_rd, rd_rd;

    regfile_4x8 u_rf (
        .clk     (clk),
        .reset   (reset),
        .we      (wb_en),
        .waddr   (wb_addr),
        .wdata   (wb_data),
        .raddr_a (rs),
        .raddr_b (rd),
        .rdata_a (rs_reg),
        .rdata_b (rd_reg)
    );

    // ---------------- flags ----------------
    logic z_q, c_q, z_eff, c_eff;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            z_q <= 1'b0;
            c_q <= 1'b0;
        end else if (flag_we) begin
            z_q <= flag_z;
            c_q <= flag_c;
        end
    end

`ifdef WB_BYPASS_EN
    assign rs_rd = (wb_en && wb_addr == rs) ? wb_data : rs_reg;
    assign rd_rd = (wb_en && wb_addr == rd) ? wb_data : rd_reg;
    assign z_eff = flag_we ? flag_z : z_q;
    assign c_eff = flag_we ? flag_c : c_q;
`else
    assign rs_rd = rs_reg;
    assign rd_rd = rd_reg;
    assign z_eff = z_q;
    assign c_eff = c_q;
`endif

    // ---------------- RUN/HALT FSM ----------------
    state_e state, state_nxt;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset)
            state <= ST_RUN;
        else
            state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            ST_RUN:  if (op == OP_HLT) state_nxt = ST_HALT;
            ST_HALT: if (resume)       state_nxt = ST_RUN;
            default: state_nxt = ST_RUN;
        endcase
    end

    // ---------------- decode ----------------
    logic [DW-1:0] br_tgt, hlt_tgt;

    assign br_tgt  = NPC + sext4(off4);
    assign hlt_tgt = NPC - DW'(1);      // points fetch back at the HLT itself

    always_comb begin
        PC_sel = 1'b0;
        Target = '0;
        rs_val = '0;
        rd_val = '0;
        alu_op = '0;
        reg_we = 1'b0;
        mem_re = 1'b0;
        mem_we = 1'b0;
        halted = 1'b0;
        if (reset) begin
            rs_val = rs_rd;
            rd_val = rd_rd;
            if (state == ST_HALT) begin
                halted = 1'b1;
                // resume drops the redirect so fetch steps past the HLT
                if (!resume) begin
                    PC_sel = 1'b1;
                    Target = hlt_tgt;
                end
            end else begin
                case (op)
                    OP_ADD, OP_SUB, OP_AND, OP_OR,
                    OP_XOR, OP_MOV, OP_SHL: begin
                        alu_op = Instr[7:4];
                        reg_we = 1'b1;
                    end
                    OP_LD: begin
                        mem_re = 1'b1;
                        reg_we = 1'b1;
                    end
                    OP_ST:  mem_we = 1'b1;
                    OP_BZ: if (z_eff) begin
                        PC_sel = 1'b1;
                        Target = br_tgt;
                    end
                    OP_BC: if (c_eff) begin
                        PC_sel = 1'b1;
                        Target = br_tgt;
                    end
                    OP_JMP: begin
                        PC_sel = 1'b1;
                        Target = br_tgt;
                    end
                    OP_JR: begin
                        PC_sel = 1'b1;
                        Target = rs_rd;
                    end
                    OP_HLT: begin
                        PC_sel = 1'b1;
                        Target = hlt_tgt;
                    end
                    default: ;  // NOP and reserved opcode
                endcase
            end
        end
    end

endmodule

// File: tb/tb_id_stage.sv
module tb_id_stage;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic [7:0] Instr = 8'h00, NPC = 8'h00;
    logic       resume = 1'b0;
    logic       wb_en = 1'b0;
    logic [1:0] wb_addr = 2'd0;
    logic [7:0] wb_data = 8'h00;
    logic       flag_we = 1'b0, flag_z = 1'b0, flag_c = 1'b0;
    logic       PC_sel;
    logic [7:0] Target, rs_val, rd_val;
    logic [3:0] alu_op;
    logic       reg_we, mem_re, mem_we, halted;

    id_stage dut (
        .clk(clk), .reset(reset), .Instr(Instr), .NPC(NPC), .resume(resume),
        .wb_en(wb_en), .wb_addr(wb_addr), .wb_data(wb_data),
        .flag_we(flag_we), .flag_z(flag_z), .flag_c(flag_c),
        .PC_sel(PC_sel), .Target(Target), .rs_val(rs_val), .rd_val(rd_val),
        .alu_op(alu_op), .reg_we(reg_we), .mem_re(mem_re), .mem_we(mem_we),
        .halted(halted)
    );

    always #5 clk = ~clk;

    typedef struct {
        string      name;
        logic       pc_sel;
        logic [7:0] target;
        logic       chk_data;
        logic [7:0] rs, rd;
        logic [3:0] alu;
        logic       rwe, mre, mwe, hlt;
    } exp_t;

    exp_t q[$];
    int   checks = 0;
    int   errors = 0;

    task automatic cmp(input string nm, input string fld, input logic [7:0] act, input logic [7:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s.%s: got 0x%02h expected 0x%02h", nm, fld, act, req);
        end
    endtask

    // monitor: the decode outputs are presented every cycle, sampled mid-cycle
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (q.size() > 0) begin
                e = q.pop_front();
                cmp(e.name, "PC_sel", {7'd0, PC_sel}, {7'd0, e.pc_sel});
                cmp(e.name, "Target", Target, e.target);
                cmp(e.name, "alu_op", {4'd0, alu_op}, {4'd0, e.alu});
                cmp(e.name, "ctl", {5'd0, reg_we, mem_re, mem_we}, {5'd0, e.rwe, e.mre, e.mwe});
                cmp(e.name, "halted", {7'd0, halted}, {7'd0, e.hlt});
                if (e.chk_data) begin
                    cmp(e.name, "rs_val", rs_val, e.rs);
                    cmp(e.name, "rd_val", rd_val, e.rd);
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic expect_o(input string nm, input logic ps, input logic [7:0] tg,
                            input logic cd, input logic [7:0] rs, input logic [7:0] rd,
                            input logic [3:0] alu, input logic rwe, input logic mre,
                            input logic mwe, input logic hlt);
        exp_t e;
        e.name = nm; e.pc_sel = ps; e.target = tg; e.chk_data = cd;
        e.rs = rs; e.rd = rd; e.alu = alu; e.rwe = rwe; e.mre = mre;
        e.mwe = mwe; e.hlt = hlt;
        q.push_back(e);
    endtask

    task automatic set_in(input logic [7:0] ins, input logic [7:0] npc);
        Instr = ins; NPC = npc;
    endtask

    task automatic set_wb(input logic en, input logic [1:0] a, input logic [7:0] d);
        wb_en = en; wb_addr = a; wb_data = d;
    endtask

    task automatic set_fl(input logic we, input logic z, input logic c);
        flag_we = we; flag_z = z; flag_c = c;
    endtask

    initial begin
        // reset held: every output forced low even with an ALU op on Instr
        tick(); set_in(8'h18, 8'h21);
        expect_o("in_reset", 0, 8'h00, 1, 8'h00, 8'h00, 4'h0, 0, 0, 0, 0);

        tick(); reset = 1'b1; set_in(8'h00, 8'h00); set_wb(1, 2'd2, 8'h5A);
        expect_o("nop_wb_r2", 0, 8'h00, 1, 8'h00, 8'h00, 4'h0, 0, 0, 0, 0);

        tick(); set_wb(0, 2'd0, 8'h00); set_in(8'h18, 8'h01);
        expect_o("add_r2_r0", 0, 8'h00, 1, 8'h00, 8'h5A, 4'h1, 1, 0, 0, 0);

        // same-cycle write to the register being read
        tick(); set_wb(1, 2'd1, 8'h33); set_in(8'h11, 8'h02);
`ifdef WB_BYPASS_EN
        expect_o("bypass_rs", 0, 8'h00, 1, 8'h33, 8'h00, 4'h1, 1, 0, 0, 0);
`else
        expect_o("no_bypass_rs", 0, 8'h00, 1, 8'h00, 8'h00, 4'h1, 1, 0, 0, 0);
`endif

        tick(); set_wb(0, 2'd0, 8'h00);
        expect_o("add_after_wb", 0, 8'h00, 1, 8'h33, 8'h00, 4'h1, 1, 0, 0, 0);

        tick(); set_in(8'h86, 8'h03);
        expect_o("ld", 0, 8'h00, 1, 8'h5A, 8'h33, 4'h0, 1, 1, 0, 0);

        tick(); set_in(8'h96, 8'h04);
        expect_o("st", 0, 8'h00, 1, 8'h5A, 8'h33, 4'h0, 0, 0, 1, 0);

        // Z written this cycle; stored Z still 0
        tick(); set_fl(1, 1, 0); set_in(8'hAE, 8'h10);
`ifdef WB_BYPASS_EN
        expect_o("bz_flag_byp", 1, 8'h0E, 1, 8'h5A, 8'h00, 4'h0, 0, 0, 0, 0);
`else
        expect_o("bz_old_z0", 0, 8'h00, 1, 8'h5A, 8'h00, 4'h0, 0, 0, 0, 0);
`endif

        tick(); set_fl(0, 0, 0);
        expect_o("bz_taken", 1, 8'h0E, 1, 8'h5A, 8'h00, 4'h0, 0, 0, 0, 0);

        tick(); set_in(8'hB5, 8'h40);
        expect_o("bc_not_taken", 0, 8'h00, 1, 8'h33, 8'h33, 4'h0, 0, 0, 0, 0);

        tick(); set_fl(1, 0, 1); set_in(8'h00, 8'h41);
        expect_o("nop_flags", 0, 8'h00, 1, 8'h00, 8'h00, 4'h0, 0, 0, 0, 0);

        tick(); set_fl(0, 0, 0); set_in(8'hAE, 8'h10);
        expect_o("bz_z0", 0, 8'h00, 1, 8'h5A, 8'h00, 4'h0, 0, 0, 0, 0);

        tick(); set_in(8'hB5, 8'h40);
        expect_o("bc_taken", 1, 8'h45, 1, 8'h33, 8'h33, 4'h0, 0, 0, 0, 0);

        tick(); set_in(8'hC3, 8'hFE);
        expect_o("jmp_wrap_up", 1, 8'h01, 0, 8'h00, 8'h00, 4'h0, 0, 0, 0, 0);

        tick(); set_in(8'hCF, 8'h00);
        expect_o("jmp_wrap_dn", 1, 8'hFF, 0, 8'h00, 8'h00, 4'h0, 0, 0, 0, 0);

        tick(); set_in(8'hD2, 8'h50);
        expect_o("jr", 1, 8'h5A, 1, 8'h5A, 8'h00, 4'h0, 0, 0, 0, 0);

        // resume while running must be ignored
        tick(); set_in(8'hE7, 8'h51); resume = 1'b1;
        expect_o("reserved", 0, 8'h00, 1, 8'h00, 8'h33, 4'h0, 0, 0, 0, 0);

        tick(); resume = 1'b0; set_in(8'h7B, 8'h52);
        expect_o("shl_run", 0, 8'h00, 1, 8'h00, 8'h5A, 4'h7, 1, 0, 0, 0);

        tick(); set_in(8'hF0, 8'h21);
        expect_o("hlt_run", 1, 8'h20, 1, 8'h00, 8'h00, 4'h0, 0, 0, 0, 0);

        // halted: write-back still lands
        tick(); set_wb(1, 2'd3, 8'h77);
        expect_o("halted", 1, 8'h20, 0, 8'h00, 8'h00, 4'h0, 0, 0, 0, 1);

        tick(); set_wb(0, 2'd0, 8'h00); resume = 1'b1;
        expect_o("resume", 0, 8'h00, 0, 8'h00, 8'h00, 4'h0, 0, 0, 0, 1);

        tick(); resume = 1'b0; set_in(8'h1C, 8'h22);
        expect_o("after_resume", 0, 8'h00, 1, 8'h00, 8'h77, 4'h1, 1, 0, 0, 0);

        tick(); set_in(8'hF0, 8'h30);
        expect_o("hlt2", 1, 8'h2F, 1, 8'h00, 8'h00, 4'h0, 0, 0, 0, 0);

        tick();
        expect_o("halted2", 1, 8'h2F, 0, 8'h00, 8'h00, 4'h0, 0, 0, 0, 1);

        // asynchronous reset mid-HALT, between clock edges
        tick(); reset = 1'b0;
        expect_o("reset_in_halt", 0, 8'h00, 1, 8'h00, 8'h00, 4'h0, 0, 0, 0, 0);

        tick(); reset = 1'b1; set_in(8'h05, 8'h01);
        expect_o("r1_cleared", 0, 8'h00, 1, 8'h00, 8'h00, 4'h0, 0, 0, 0, 0);

        tick(); set_in(8'h0A, 8'h02);
        expect_o("r2_cleared", 0, 8'h00, 1, 8'h00, 8'h00, 4'h0, 0, 0, 0, 0);

        tick(); set_in(8'h0F, 8'h03);
        expect_o("r3_cleared", 0, 8'h00, 1, 8'h00, 8'h00, 4'h0, 0, 0, 0, 0);

        // flags were cleared too: BZ/BC not taken
        tick(); set_in(8'hA0, 8'h04);
        expect_o("z_cleared", 0, 8'h00, 1, 8'h00, 8'h00, 4'h0, 0, 0, 0, 0);

        tick(); set_in(8'hB0, 8'h05);
        expect_o("c_cleared", 0, 8'h00, 1, 8'h00, 8'h00, 4'h0, 0, 0, 0, 0);

        begin
            int n = 0;
            while (q.size() > 0 && n < 10) begin
                @(posedge clk);
                n++;
            end
        end
        checks++;
        if (q.size() != 0) begin
            errors++;
            $display("FAIL drain: %0d entries left, expected 0", q.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/id_stage.md
Name: id_stage

Overview:
- Decode stage of the 8-bit single-cycle processor; sits directly downstream of instruction fetch.
- Consumes fetched Instr and NPC; holds the 4x8 register file, Z/C flags and a RUN/HALT state machine.
- Drives datapath controls and returns PC_sel/Target to fetch for branches, jumps and halt.

Parameters:
- NREGS, 4, register count; fixed by the 2-bit register fields.
- DW, 8, data and address width.

Ports:
- clk  in  1  system clock, rising edge
- reset  in  1  asynchronous, active-low reset
- Instr  in  8  instruction from fetch
- NPC  in  8  PC+1 from fetch
- resume  in  1  single-cycle pulse that leaves HALT
- wb_en  in  1  register write enable from write-back
- wb_addr  in  2  write-back register index
- wb_data  in  8  write-back data
- flag_we  in  1  flag update strobe from ALU
- flag_z  in  1  new Z
- flag_c  in  1  new C
- PC_sel  out  1  1 = fetch loads Target
- Target  out  8  next PC when PC_sel=1
- rs_val  out  8  R[Instr[1:0]]
- rd_val  out  8  R[Instr[3:2]]
- alu_op  out  4  Instr[7:4] for ALU-class ops, else 0
- reg_we  out  1  instruction writes rd
- mem_re  out  1  load
- mem_we  out  1  store
- halted  out  1  state == HALT

Behaviour:
- Format: op=Instr[7:4], rd=Instr[3:2], rs=Instr[1:0], off4=Instr[3:0].
- Opcodes:
  - 0 NOP
  - 1 ADD, 2 SUB, 3 AND, 4 OR, 5 XOR, 6 MOV, 7 SHL: ALU-class; reg_we=1.
  - 8 LD: mem_re=1, reg_we=1.
  - 9 ST: mem_we=1.
  - A BZ, B BC, C JMP: relative branches.
  - D JR: Target=R[rs], PC_sel=1.
  - E reserved, decodes as NOP.
  - F HLT.
- Branch target: Target = NPC + sign_extend(off4), 8-bit wrap-around (NPC=0xFE with off4=0x3 gives 0x01; NPC=0x00 with off4=0xF gives 0xFF).
- Branch conditions: BZ taken iff Z=1; BC taken iff C=1; JMP always taken. Not taken: PC_sel=0, Target=0.
- Decode is combinational, zero latency. Register file, flags and state update on the rising edge of clk.
- Register file: R[wb_addr] <= wb_data when wb_en. Reads are asynchronous.
- Flags: {Z,C} <= {flag_z,flag_c} when flag_we.
- State machine:
  - RUN -> HALT when op==F.
  - HALT -> RUN on resume=1.
  - In RUN with op==F: PC_sel=1, Target=NPC-1 (re-fetch the HLT).
  - In HALT: all controls 0 except PC_sel=1, Target=NPC-1; register and flag writes from wb_en/flag_we still apply.
  - resume in HALT: PC_sel=0 that cycle, so fetch advances past the HLT; state returns to RUN.
  - resume in RUN: ignored.
- Reset low, asynchronous: all registers, flags = 0; state = RUN. While reset is low, every output is forced to 0. Reset mid-HALT returns to RUN.
- Same-cycle wb_en to the register being read: the old value is returned (unless WB_BYPASS_EN).

Optional Feature:
- Macro WB_BYPASS_EN.
- Defined: rs_val/rd_val return wb_data when wb_en and wb_addr match; BZ/BC evaluate flag_z/flag_c when flag_we=1 that cycle.
- Undefined: reads see only the registered values.

Decomposition:
- Package id_pkg holds: opcode constants OP_NOP..OP_HLT, state encoding ST_RUN/ST_HALT, field widths.
- One natural sub-module, regfile_4x8: 2 asynchronous read ports, 1 synchronous write port, async active-low clear.
- Flags and FSM stay in id_stage.

Test Plan:
- Write-back then read: wb R2=0x5A, then Instr=0x18 (ADD rd=2, rs=0) -> rd_val=0x5A, rs_val=0x00, alu_op=1, reg_we=1, PC_sel=0.
- Conditional branch: flags Z=1; Instr=0xAE, NPC=0x10 -> PC_sel=1, Target=0x0E. Then Z=0 -> PC_sel=0.
- Branch wrap: Instr=0xC3, NPC=0xFE -> Target=0x01. Instr=0xCF, NPC=0x00 -> Target=0xFF.
- Halt: Instr=0xF0, NPC=0x21 -> PC_sel=1, Target=0x20. Next cycle halted=1. resume pulse -> PC_sel=0, then halted=0.
- Reset mid-HALT: drop reset asynchronously -> halted=0 and all outputs 0 immediately; R0..R3 read 0 after release.
- Bypass (WB_BYPASS_EN defined): wb_en=1, wb_addr=1, wb_data=0x33 with Instr rs=1 in the same cycle -> rs_val=0x33. Undefined -> old value.
